// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered output stage behind the 32-bit ALU. Captures result, carry and
// overflow, derives zero/negative, masks carry/overflow for ops that do not
// define them, and hands entries downstream over valid/ready. A two-entry
// skid buffer (main M, skid S) keeps in_ready a pure register output.
// A sticky overflow bit records any accepted masked overflow until cleared.
module alu_result_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carryout,
  input  logic             in_overflow,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_negative,
  output logic             sticky_ovf,
  input  logic             clear_sticky
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             neg;
  } entry_t;

  localparam entry_t ENTRY_ZERO = '0;

  entry_t m_q, m_d;
  entry_t s_q, s_d;
  logic   m_valid_q, m_valid_d;
  logic   s_valid_q, s_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   sticky_q, sticky_d;

  entry_t in_entry;
  logic   arith_op;
  logic   acc;
  logic   dep;

  // Build the entry to be captured: carry/overflow only meaningful for ADD/SUB.
  always_comb begin
    arith_op        = (in_op == 3'd0) || (in_op == 3'd1);
    in_entry        = ENTRY_ZERO;
    in_entry.result = in_result;
    in_entry.carry  = arith_op & in_carryout;
    in_entry.ovf    = arith_op & in_overflow;
    in_entry.zero   = (in_result == '0);
    in_entry.neg    = in_result[WIDTH-1];
  end

  assign acc = in_valid & in_ready_q;
  assign dep = m_valid_q & out_ready;

  // Next-state for the M/S skid pair; in_ready follows skid occupancy.
  // With S full in_ready is low, so an accept alongside an M<=S refill
  // cannot happen and S is simply drained.
  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;

    if (!m_valid_q) begin
      if (acc) begin
        m_d       = in_entry;
        m_valid_d = 1'b1;
      end
    end else if (dep) begin
      if (s_valid_q) begin
        m_d       = s_q;
        s_valid_d = 1'b0;
      end else if (acc) begin
        m_d       = in_entry;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (acc) begin
      s_d       = in_entry;
      s_valid_d = 1'b1;
    end

    in_ready_d = ~s_valid_d;
  end

  // Sticky overflow: a set on this edge beats a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (acc && in_entry.ovf) begin
      sticky_d = 1'b1;
    end else if (clear_sticky) begin
      sticky_d = 1'b0;
    end
  end

  // State registers; synchronous reset empties both entries and zeroes outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q        <= ENTRY_ZERO;
      s_q        <= ENTRY_ZERO;
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
      sticky_q   <= 1'b0;
    end else begin
      m_q        <= m_d;
      s_q        <= s_d;
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
      sticky_q   <= sticky_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = m_valid_q;
  assign out_result   = m_q.result;
  assign out_carry    = m_q.carry;
  assign out_overflow = m_q.ovf;
  assign out_zero     = m_q.zero;
  assign out_negative = m_q.neg;
  assign sticky_ovf   = sticky_q;

endmodule
